// File: rtl/tlp_np_req_arbiter_if.sv
// Request, header-output and completion handshakes of the non-posted request arbiter.
// slave: the arbiter side; master: functions, header builder and completion source.
interface tlp_np_req_arbiter_if #(
    parameter int unsigned NUM_FUNC = 4
);
    localparam int unsigned FIDX_W = $clog2(NUM_FUNC);

    logic [NUM_FUNC-1:0] req_valid;
    logic [NUM_FUNC-1:0] req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_req_id;
    logic [7:0]          out_tag;
    logic [FIDX_W-1:0]   out_func_idx;
    logic                cpl_valid;
    logic [7:0]          cpl_tag;

    modport master (
        output req_valid, out_ready, cpl_valid, cpl_tag,
        input  req_ready, out_valid, out_req_id, out_tag, out_func_idx
    );

    modport slave (
        input  req_valid, out_ready, cpl_valid, cpl_tag,
        output req_ready, out_valid, out_req_id, out_tag, out_func_idx
    );
endinterface

// File: rtl/tlp_np_req_arbiter.sv
// Round-robin arbiter for the non-posted TLP request path with tag pool and Requester ID build.
// Optional feature: define TLP_EXT_TAG_EN for 8-bit tags (NUM_TAGS up to 256).
module tlp_np_req_arbiter #(
    parameter int unsigned NUM_FUNC = 4,
    parameter int unsigned NUM_TAGS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_ari_en_i,
    input  logic [7:0]                cfg_bus_num_i,
    input  logic [NUM_FUNC*5-1:0]     func_dev_num_i,
    input  logic [NUM_FUNC*8-1:0]     func_fn_num_i,
    input  logic                      quiesce_req_i,
    output logic [8:0]                tag_free_cnt_o,
    output logic                      cpl_err_o,
    output logic                      quiesced_o,
    tlp_np_req_arbiter_if.slave       bus
);
    localparam int unsigned FIDX_W    = $clog2(NUM_FUNC);
    localparam int unsigned TAG_IDX_W = $clog2(NUM_TAGS);
`ifdef TLP_EXT_TAG_EN
    localparam int unsigned MAX_TAGS  = 256;
`else
    localparam int unsigned MAX_TAGS  = 32;
`endif

    if (NUM_TAGS > MAX_TAGS || NUM_TAGS < 2 || NUM_FUNC < 2 || NUM_FUNC > 8) begin : g_param_err
        $error("tlp_np_req_arbiter: NUM_FUNC/NUM_TAGS out of supported range");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_QSC   = 2'd1,
        ST_QUIET = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [FIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_TAGS-1:0]   tag_alloc_q, tag_alloc_d;
    logic [8:0]            free_cnt_q, free_cnt_d;
    logic                  cpl_err_q, cpl_err_d;
    logic                  quiesced_q, quiesced_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           out_req_id_q, out_req_id_d;
    logic [7:0]            out_tag_q, out_tag_d;
    logic [FIDX_W-1:0]     out_fidx_q, out_fidx_d;

    logic [4:0]            dev_arr [NUM_FUNC];
    logic [7:0]            fn_arr  [NUM_FUNC];
    int unsigned           arb_cand;
    logic                  win_found;
    logic [FIDX_W-1:0]     win_idx;
    logic [TAG_IDX_W-1:0]  free_idx;
    logic                  grant_c;
    logic [NUM_FUNC-1:0]   req_ready_c;
    logic                  cpl_in_range;
    logic [TAG_IDX_W-1:0]  cpl_idx;
    logic                  cpl_ok;

    for (genvar g = 0; g < NUM_FUNC; g++) begin : g_unpack
        assign dev_arr[g] = func_dev_num_i[5*g +: 5];
        assign fn_arr[g]  = func_fn_num_i[8*g +: 8];
    end

    // Round-robin winner search starting at the pointer, plus lowest free tag.
    always_comb begin
        arb_cand  = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_FUNC; k++) begin
            arb_cand = (32'(rr_ptr_q) + k) % NUM_FUNC;
            if (!win_found && bus.req_valid[FIDX_W'(arb_cand)]) begin
                win_found = 1'b1;
                win_idx   = FIDX_W'(arb_cand);
            end
        end
        free_idx = '0;
        for (int t = int'(NUM_TAGS) - 1; t >= 0; t--) begin
            if (!tag_alloc_q[TAG_IDX_W'(t)]) free_idx = TAG_IDX_W'(t);
        end
    end

    // Grant qualification and completion decode.
    always_comb begin
        grant_c = !rst && (state_q == ST_RUN) && !quiesce_req_i && win_found &&
                  (free_cnt_q != 9'd0) && (!out_valid_q || bus.out_ready);
        req_ready_c = '0;
        if (grant_c) req_ready_c[win_idx] = 1'b1;
`ifdef TLP_EXT_TAG_EN
        cpl_in_range = ({1'b0, bus.cpl_tag} < 9'(NUM_TAGS));
`else
        cpl_in_range = (bus.cpl_tag[7:5] == 3'd0) && ({1'b0, bus.cpl_tag[4:0]} < 6'(NUM_TAGS));
`endif
        cpl_idx = bus.cpl_tag[TAG_IDX_W-1:0];
        cpl_ok  = bus.cpl_valid && cpl_in_range && tag_alloc_q[cpl_idx];
    end

    // Next-state: FSM, tag pool, pointer and output register.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tag_alloc_d  = tag_alloc_q;
        free_cnt_d   = free_cnt_q;
        cpl_err_d    = cpl_err_q;
        out_valid_d  = out_valid_q;
        out_req_id_d = out_req_id_q;
        out_tag_d    = out_tag_q;
        out_fidx_d   = out_fidx_q;

        case (state_q)
            ST_RUN:   if (quiesce_req_i) state_d = ST_QSC;
            ST_QSC: begin
                if (!quiesce_req_i)
                    state_d = ST_RUN;
                else if (!out_valid_q && free_cnt_q == 9'(NUM_TAGS))
                    state_d = ST_QUIET;
            end
            ST_QUIET: if (!quiesce_req_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        quiesced_d = (state_d == ST_QUIET);

        if (cpl_ok)
            tag_alloc_d[cpl_idx] = 1'b0;
        else if (bus.cpl_valid)
            cpl_err_d = 1'b1;

        if (grant_c) begin
            tag_alloc_d[free_idx] = 1'b1;
            rr_ptr_d     = (win_idx == FIDX_W'(NUM_FUNC - 1)) ? '0 : win_idx + 1'b1;
            out_valid_d  = 1'b1;
            out_req_id_d = cfg_ari_en_i ? {cfg_bus_num_i, fn_arr[win_idx]}
                                        : {cfg_bus_num_i, dev_arr[win_idx], fn_arr[win_idx][2:0]};
            out_tag_d    = 8'(free_idx);
            out_fidx_d   = win_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Simultaneous grant and free leave the count unchanged.
        case ({grant_c, cpl_ok})
            2'b10:   free_cnt_d = free_cnt_q - 9'd1;
            2'b01:   free_cnt_d = free_cnt_q + 9'd1;
            default: free_cnt_d = free_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= '0;
            tag_alloc_q  <= '0;
            free_cnt_q   <= 9'(NUM_TAGS);
            cpl_err_q    <= 1'b0;
            quiesced_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_req_id_q <= '0;
            out_tag_q    <= '0;
            out_fidx_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tag_alloc_q  <= tag_alloc_d;
            free_cnt_q   <= free_cnt_d;
            cpl_err_q    <= cpl_err_d;
            quiesced_q   <= quiesced_d;
            out_valid_q  <= out_valid_d;
            out_req_id_q <= out_req_id_d;
            out_tag_q    <= out_tag_d;
            out_fidx_q   <= out_fidx_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_req_id   = out_req_id_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.out_func_idx = out_fidx_q;
    assign tag_free_cnt_o   = free_cnt_q;
    assign cpl_err_o        = cpl_err_q;
    assign quiesced_o       = quiesced_q;
endmodule
